// File: rtl/bit_rev_loader.sv
// One 1024-point bit-reversal pass: walks the bit-reversal ROM, reads the sample RAM at the
// reversed addresses and writes the samples in natural order into the FFT RAM, two per cycle.
module bit_rev_loader #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 9,
    parameter int PTR_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic [IDX_W-1:0]  RomAddr,
    input  logic [PTR_W-1:0]  RomDoutA,
    input  logic [PTR_W-1:0]  RomDoutB,
    output logic [PTR_W-1:0]  SrcAddrA,
    output logic [PTR_W-1:0]  SrcAddrB,
    input  logic [DATA_W-1:0] SrcDataA,
    input  logic [DATA_W-1:0] SrcDataB,
    output logic              DstWe,
    output logic [PTR_W-1:0]  DstAddrA,
    output logic [PTR_W-1:0]  DstAddrB,
    output logic [DATA_W-1:0] DstDataA,
    output logic [DATA_W-1:0] DstDataB,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        dbg_state
);

    // Handshake: Start is a level sampled only in IDLE; Done is a one-cycle pulse and
    // DstWe qualifies DstAddr*/DstData* in the same cycle, with no backpressure.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [1:0]       drain_cnt;
    logic             v1, v2, v3;
    logic [IDX_W-1:0] i1, i2, i3;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (idx == IDX_LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx parks on the last index through DRAIN/DONE so no wrap to 0 is ever issued.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    idx       <= '0;
                    drain_cnt <= 2'd0;
                end
                RUN: begin
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                    drain_cnt <= 2'd0;
                end
                DRAIN:   drain_cnt <= drain_cnt + 2'd1;
                DONE:    idx <= '0;
                default: idx <= '0;
            endcase
        end
    end

    // Index and valid travel together: ROM latency, then source-address register, then RAM latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            i1       <= '0;
            i2       <= '0;
            i3       <= '0;
            SrcAddrA <= '0;
            SrcAddrB <= '0;
        end else begin
            v1 <= (state == RUN);
            i1 <= idx;
            v2 <= v1;
            i2 <= i1;
            v3 <= v2;
            i3 <= i2;
            if (v1) begin
                SrcAddrA <= RomDoutA;
                SrcAddrB <= RomDoutB;
            end
        end
    end

    always_comb begin
        RomAddr   = idx;
        Busy      = (state == RUN) || (state == DRAIN);
        Done      = (state == DONE);
        dbg_state = state;
        DstWe     = v3;
        DstAddrA  = v3 ? {i3, 1'b0} : '0;
        DstAddrB  = v3 ? {i3, 1'b1} : '0;
        DstDataA  = v3 ? SrcDataA : '0;
        DstDataB  = v3 ? SrcDataB : '0;
    end

endmodule

// File: tb/tb_bit_rev_loader.sv
// Bench for bit_rev_loader: bit-reversal ROM and sample RAM models, FFT RAM capture,
// cycle-table checks of one pass plus ignored-start, mid-pass reset and back-to-back runs.
module tb_bit_rev_loader;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 9;
    localparam int PTR_W  = 10;
    localparam int SB_W   = 2 * PTR_W + 2 * DATA_W;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Start = 1'b0;
    logic [IDX_W-1:0]  RomAddr;
    logic [PTR_W-1:0]  RomDoutA = '0;
    logic [PTR_W-1:0]  RomDoutB = '0;
    logic [PTR_W-1:0]  SrcAddrA, SrcAddrB;
    logic [DATA_W-1:0] SrcDataA = '0;
    logic [DATA_W-1:0] SrcDataB = '0;
    logic              DstWe;
    logic [PTR_W-1:0]  DstAddrA, DstAddrB;
    logic [DATA_W-1:0] DstDataA, DstDataB;
    logic              Busy, Done;
    logic [1:0]        dbg_state;

    bit_rev_loader #(.DATA_W(DATA_W), .IDX_W(IDX_W), .PTR_W(PTR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .RomAddr(RomAddr), .RomDoutA(RomDoutA), .RomDoutB(RomDoutB),
        .SrcAddrA(SrcAddrA), .SrcAddrB(SrcAddrB), .SrcDataA(SrcDataA), .SrcDataB(SrcDataB),
        .DstWe(DstWe), .DstAddrA(DstAddrA), .DstAddrB(DstAddrB),
        .DstDataA(DstDataA), .DstDataB(DstDataB),
        .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PTR_W-1:0] bitrev10(input logic [PTR_W-1:0] a);
        logic [PTR_W-1:0] r;
        for (int b = 0; b < PTR_W; b++) r[b] = a[PTR_W-1-b];
        return r;
    endfunction

    // ---------------- memory models ----------------
    logic [DATA_W-1:0] fft_mem [0:1023];

    always @(posedge Clk) begin
        RomDoutA <= bitrev10({RomAddr, 1'b0});
        RomDoutB <= bitrev10({RomAddr, 1'b1});
        SrcDataA <= DATA_W'(SrcAddrA);
        SrcDataB <= DATA_W'(SrcAddrB);
        if (DstWe) begin
            fft_mem[DstAddrA] <= DstDataA;
            fft_mem[DstAddrB] <= DstDataB;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    bit sb_on = 1'b0;
    int wr_cnt, done_cnt, first_wr, last_wr, gap_err, last_done;

    task automatic clr_mon();
        wr_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1; gap_err = 0; last_done = -1;
    endtask

    always @(negedge Clk) begin
        if (DstWe) begin
            if (wr_cnt == 0) first_wr = cyc;
            else if (cyc != last_wr + 1) gap_err++;
            last_wr = cyc;
            wr_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) chk("sb_extra_write", 64'(DstAddrA), 64'hffff);
                else chk("sb_write", 64'({DstAddrA, DstAddrB, DstDataA, DstDataB}),
                         64'(exp_q.pop_front()));
            end
        end
        if (Done) begin
            done_cnt++;
            last_done = cyc;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int               off;
        logic [IDX_W-1:0] rom;
        logic             we;
        logic [PTR_W-1:0] da;
        logic [PTR_W-1:0] db;
        logic             busy;
        logic             done;
        logic             src_chk;
        logic [PTR_W-1:0] sa;
        logic [PTR_W-1:0] sb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int off, input int rom, input bit we, input int da, input int db,
                       input bit busy, input bit done, input bit sc, input int sa, input int sb);
        vec_t v;
        v.off = off; v.rom = IDX_W'(rom); v.we = we; v.da = PTR_W'(da); v.db = PTR_W'(db);
        v.busy = busy; v.done = done; v.src_chk = sc; v.sa = PTR_W'(sa); v.sb = PTR_W'(sb);
        tbl.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_pulse(output int k);
        @(negedge Clk);
        Start = 1'b1;
        k = cyc;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Entered at the negedge of cycle k+1; leaves at the negedge of cycle k+518.
    task automatic run_table(input int k);
        int t;
        t = 0;
        while (cyc < k + 518) begin
            if (t < tbl.size() && tbl[t].off == cyc - k) begin
                chk("tbl_rom", 64'(RomAddr), 64'(tbl[t].rom));
                chk("tbl_we", 64'(DstWe), 64'(tbl[t].we));
                chk("tbl_busy", 64'(Busy), 64'(tbl[t].busy));
                chk("tbl_done", 64'(Done), 64'(tbl[t].done));
                if (tbl[t].we) begin
                    chk("tbl_dst_a", 64'(DstAddrA), 64'(tbl[t].da));
                    chk("tbl_dst_b", 64'(DstAddrB), 64'(tbl[t].db));
                end
                if (tbl[t].src_chk) begin
                    chk("tbl_src_a", 64'(SrcAddrA), 64'(tbl[t].sa));
                    chk("tbl_src_b", 64'(SrcAddrB), 64'(tbl[t].sb));
                end
                t++;
            end
            @(negedge Clk);
        end
        chk("tbl_all_applied", 64'(t), 64'(tbl.size()));
    endtask

    task automatic pass_summary(input int k);
        #1;
        chk("pass_writes", 64'(wr_cnt), 64'd512);
        chk("pass_done_cnt", 64'(done_cnt), 64'd1);
        chk("pass_first_wr", 64'(first_wr), 64'(k + 4));
        chk("pass_last_wr", 64'(last_wr), 64'(k + 515));
        chk("pass_gaps", 64'(gap_err), 64'd0);
        chk("pass_done_cyc", 64'(last_done), 64'(k + 516));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k, errs, chk_at;
        int dq[$];

        for (int n = 0; n < 1024; n++) fft_mem[n] = 16'hdead;
        clr_mon();
        add(1,   0,   0, 0,    0,    1, 0, 0, 0,   0);
        add(2,   1,   0, 0,    0,    1, 0, 0, 0,   0);
        add(3,   2,   0, 0,    0,    1, 0, 1, 0,   512);
        add(4,   3,   1, 0,    1,    1, 0, 0, 0,   0);
        add(8,   7,   1, 8,    9,    1, 0, 1, 320, 832);
        add(9,   8,   1, 10,   11,   1, 0, 0, 0,   0);
        add(100, 99,  1, 192,  193,  1, 0, 0, 0,   0);
        add(512, 511, 1, 1016, 1017, 1, 0, 0, 0,   0);
        add(513, 511, 1, 1018, 1019, 1, 0, 0, 0,   0);
        add(515, 511, 1, 1022, 1023, 1, 0, 0, 0,   0);
        add(516, 511, 0, 0,    0,    0, 1, 0, 0,   0);
        add(517, 0,   0, 0,    0,    0, 0, 0, 0,   0);

        // reset then idle
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        chk("reset_outputs", 64'({RomAddr, SrcAddrA, SrcAddrB, DstWe, DstAddrA, DstAddrB,
                                  Busy, Done, dbg_state}), 64'd0);
        repeat (20) @(negedge Clk);
        #1;
        chk("idle_outputs", 64'({RomAddr, DstWe, DstDataA, DstDataB, Busy, Done}), 64'd0);
        chk("idle_writes", 64'(wr_cnt), 64'd0);
        chk("idle_done", 64'(done_cnt), 64'd0);

        // single pass with scoreboard and full RAM content check
        for (int i = 0; i < 512; i++)
            exp_q.push_back({PTR_W'(2 * i), PTR_W'(2 * i + 1),
                             DATA_W'(bitrev10(PTR_W'(2 * i))), DATA_W'(bitrev10(PTR_W'(2 * i + 1)))});
        sb_on = 1'b1;
        clr_mon();
        start_pulse(k);
        run_table(k);
        pass_summary(k);
        sb_on = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        errs = 0;
        for (int n = 0; n < 1024; n++)
            if (fft_mem[n] !== DATA_W'(bitrev10(PTR_W'(n)))) errs++;
        chk("fft_ram_all", 64'(errs), 64'd0);
        chk("fft_ram_1", 64'(fft_mem[1]), 64'd512);
        chk("fft_ram_2", 64'(fft_mem[2]), 64'd256);
        chk("fft_ram_1023", 64'(fft_mem[1023]), 64'd1023);

        // Start during RUN and during DONE is ignored
        clr_mon();
        start_pulse(k);
        repeat (99) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (415) @(negedge Clk);
        chk("ign_done_cycle", 64'(Done), 64'd1);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("ign_idle_after_done", 64'({Busy, RomAddr}), 64'd0);
        repeat (600) @(negedge Clk);
        #1;
        chk("ign_writes", 64'(wr_cnt), 64'd512);
        chk("ign_done_cnt", 64'(done_cnt), 64'd1);
        chk("ign_busy", 64'(Busy), 64'd0);

        // asynchronous reset mid-pass
        clr_mon();
        start_pulse(k);
        repeat (199) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_outputs", 64'({RomAddr, DstWe, DstAddrA, DstDataA, Busy, Done, dbg_state}), 64'd0);
        chk("rst_writes_before", 64'(wr_cnt), 64'd197);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (600) @(negedge Clk);
        #1;
        chk("rst_no_more_writes", 64'(wr_cnt), 64'd197);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        clr_mon();
        start_pulse(k);
        run_table(k);
        pass_summary(k);

        // Start held high: back-to-back passes
        clr_mon();
        chk_at = -1;
        @(negedge Clk);
        Start = 1'b1;
        k = cyc;
        for (int n = 0; n < 2100; n++) begin
            @(negedge Clk);
            if (n == 2000) Start = 1'b0;
            if (cyc == chk_at) chk("held_restart", 64'({Busy, RomAddr}), 64'({1'b1, 9'd0}));
            if (Done) begin
                dq.push_back(cyc);
                if (Start) chk_at = cyc + 2;
            end
        end
        #1;
        chk("held_done_cnt", 64'(dq.size()), 64'd4);
        if (dq.size() > 0) chk("held_first_done", 64'(dq[0]), 64'(k + 516));
        for (int i = 1; i < dq.size(); i++)
            chk("held_done_period", 64'(dq[i] - dq[i-1]), 64'd517);
        chk("held_writes", 64'(wr_cnt), 64'(4 * 512));
        chk("held_gaps_idle", 64'(Busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_rev_loader.md
Name: bit_rev_loader

Overview:
- Sequences one 1024-point bit-reversal pass for the FFT. It drives the bit-reversal ROM (`bitRevRam`, 9-bit index in, two 10-bit reversed addresses out) and reads the sample RAM at those addresses. It writes the samples in natural order into the FFT working RAM, two per cycle.
- Sits between sample capture and the FFT butterfly controller. It is started by the top-level controller and reports completion with `Done`.

Parameters:
- DATA_W, 16, sample word width.
- IDX_W, 9, ROM index width (512 pairs = 1024 points).
- PTR_W, 10, RAM address width (IDX_W+1).

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin a pass; sampled only in IDLE.
- RomAddr  out  IDX_W  index to bitRevRam.addr.
- RomDoutA  in  PTR_W  bitRevRam.DoutA = bitrev10(2*idx); 1-cycle registered latency.
- RomDoutB  in  PTR_W  bitRevRam.DoutB = bitrev10(2*idx+1); 1-cycle latency.
- SrcAddrA  out  PTR_W  sample RAM port A read address.
- SrcAddrB  out  PTR_W  sample RAM port B read address.
- SrcDataA  in  DATA_W  sample RAM port A data; 1-cycle read latency.
- SrcDataB  in  DATA_W  sample RAM port B data; 1-cycle read latency.
- DstWe  out  1  write enable, both FFT RAM ports.
- DstAddrA  out  PTR_W  FFT RAM port A write address (even).
- DstAddrB  out  PTR_W  FFT RAM port B write address (odd).
- DstDataA  out  DATA_W  FFT RAM port A write data.
- DstDataB  out  DATA_W  FFT RAM port B write data.
- Busy  out  1  pass in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, `Reset_n`=0) sets all outputs to 0, state to IDLE, index counter to 0, and clears all pipeline valid bits.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `Start`=1 at an edge (edge k). Index counter is cleared.
  - RUN: `RomAddr` = idx, idx increments each cycle. When `RomAddr`=511 is issued, go to DRAIN; no wrap to 0 is ever issued.
  - DRAIN: stays exactly 3 cycles until the last write has issued, then goes to DONE.
  - DONE: `Done`=1 for one cycle, then IDLE.
- Pipeline per index i, issued in cycle c:
  - c+1: ROM data valid. The block registers `RomDoutA`/`RomDoutB` into `SrcAddrA`/`SrcAddrB`.
  - c+2: `SrcAddr` presented to sample RAM.
  - c+3: `SrcData` valid. Same cycle: `DstWe`=1, `DstAddrA`={i,1'b0}, `DstAddrB`={i,1'b1}, `DstDataA`=`SrcDataA`, `DstDataB`=`SrcDataB`.
  - Dst data is combinational passthrough. Dst addresses come from the index delayed 3 stages.
- Timing relative to the `Start` edge k:
  - `RomAddr`=0 in cycle k+1; `RomAddr`=511 in k+512.
  - Writes occur in cycles k+4..k+515: exactly 512 `DstWe` cycles, contiguous.
  - `Done` is high in k+516.
  - `Busy` is high k+1..k+515 inclusive; it is low in the `Done` cycle.
- `DstWe` is driven only by a valid bit travelling with the index. No write occurs in IDLE, DONE, or the first 3 cycles of RUN.
- `Start` while `Busy` or in DONE is ignored; it is not queued.
- `Start` held high continuously starts a new pass in the cycle after DONE returns to IDLE.
- `Reset_n` low mid-pass aborts immediately. Valid bits are cleared, so no further `DstWe`, and no `Done` pulse follows.
- `SrcAddr` holds its last value when idle. `RomAddr` returns to 0 in IDLE.

Test Plan:
- Reset then idle 20 cycles, `Start`=0 → all outputs 0, no `DstWe`.
- Single `Start` pulse at edge k, ROM model = bitrev10 → `RomAddr` 0 at k+1.
  - Write at k+9: `DstAddrA`=10, `DstAddrB`=11, `SrcAddr` used 320/832.
  - 512 writes total; `Done` only at k+516.
- Sample RAM preloaded with data = address → FFT RAM[n] = bitrev10(n) for all n. Spot checks: [1]=512, [2]=256, [1023]=1023.
- `Start` pulsed at k+100 and k+516 → ignored; exactly one pass and one `Done`.
- `Reset_n` pulled low at k+200 for 2 cycles → outputs 0 asynchronously, no writes after, no `Done`. A new `Start` afterwards completes a normal pass.
- `Start` held high 2000 cycles → back-to-back passes, a new `RomAddr`=0 the cycle after each `Done`+1, `Done` every 517 cycles.
